mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive data-port grants while the fetch request waits.
REQ-002 SHALL have parameter TIMEOUT, default 64: max cycles in a busy state without mem_ready_i.
REQ-003 SHALL have clk_i  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have if_req_i  in  1  fetch request, level, held until if_ack_o; if_addr_i  in  32  fetch address.
REQ-006 SHALL have if_ack_o  out  1  one-cycle completion pulse; if_rdata_o  out  32  fetched word.
REQ-007 SHALL have dm_req_i  in  1  data request, level, held until dm_ack_o; dm_we_i  in  1  write enable; dm_addr_i  in  32; dm_wdata_i  in  32.
REQ-008 SHALL have dm_ack_o  out  1  completion pulse; dm_rdata_o  out  32  load data.
REQ-009 SHALL have err_o  out  1  pulse with an ack when the access timed out.
REQ-010 SHALL have mem_en_o  out  1, mem_we_o  out  1, mem_addr_o  out  32, mem_wdata_o  out  32: shared single-port memory command.
REQ-011 SHALL have mem_rdata_i  in  32, mem_ready_i  in  1: memory response, valid when mem_ready_i=1.
REQ-012 SHALL have if_stall_o  out  1 = if_req_i & ~if_ack_o; dm_stall_o  out  1 = dm_req_i & ~dm_ack_o (combinational).

Function
REQ-013 SHALL implement FSM states IDLE, IF_BUSY, DM_BUSY.
REQ-014 In IDLE, SHALL grant on any pending request: dm wins, unless if_req_i=1 and starve count = STARVE_MAX, then if wins.
REQ-015 SHALL NOT grant a requester in the cycle its own ack_o is high (req still asserted that cycle).
REQ-016 On grant, SHALL latch addr/we/wdata; from next cycle mem_en_o=1 and mem_* driven from latches until exit of busy state.
REQ-017 IF_BUSY SHALL drive mem_we_o=0 regardless of dm_we_i.
REQ-018 In busy state with mem_ready_i=1, SHALL return to IDLE and pulse matching ack_o next cycle; rdata_o registered from mem_rdata_i at that edge.
REQ-019 dm_rdata_o SHALL hold its previous value on write completions; both rdata_o hold until the next read completion.
REQ-020 Minimum latency: req in IDLE cycle 0 -> mem_en_o cycle 1 -> ready cycle 1 -> ack cycle 2.
REQ-021 Busy-cycle counter SHALL clear on entry; if it reaches TIMEOUT without ready, SHALL return to IDLE and pulse ack_o with err_o=1, rdata_o unchanged.
REQ-022 Starve counter SHALL increment on each dm grant while if_req_i=1, clear on any if grant, saturate at STARVE_MAX.
REQ-023 mem_ready_i in IDLE SHALL be ignored.
REQ-024 if_ack_o and dm_ack_o SHALL never be high in the same cycle; at most one memory access outstanding.

Reset
REQ-025 On rst_i: state IDLE, both counters 0, mem_en_o/mem_we_o/acks/err_o 0, mem_addr_o/mem_wdata_o/rdata_o 32'h0.
REQ-026 Reset mid-access SHALL abandon it with no ack; a late mem_ready_i is ignored per REQ-023.

Structure
REQ-027 State encoding and STARVE_MAX/TIMEOUT defaults SHALL live in a shared package/header mem_arb_pkg.
REQ-028 The timeout counter SHALL be a sub-module mem_arb_timer (clear, enable, expired output); all else flat.

Verification
REQ-029 dm read addr 0x10, ready 3 cycles after mem_en_o -> dm_ack_o once, dm_rdata_o = mem_rdata_i, err_o=0.
REQ-030 if_req and dm_req both asserted in IDLE, dm re-requesting 5 times -> dm granted 4 times, 5th grant to if, counter 0.
REQ-031 dm write 0xDEADBEEF to 0x20 -> mem_we_o=1, mem_wdata_o=0xDEADBEEF, dm_rdata_o unchanged.
REQ-032 ready never asserted -> ack+err_o at busy cycle 64, state IDLE, next request served normally.
REQ-033 rst_i pulse during IF_BUSY, then ready -> no if_ack_o, all outputs at reset values.
REQ-034 ready in the grant's first busy cycle -> ack exactly 2 cycles after request; same requester not re-granted during ack cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction-fetch / data-memory arbiter:
// FSM state encoding and default tuning parameters.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_DM_BUSY = 2'd2
    } arb_state_e;

    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TIMEOUT_DEF    = 64;

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog: counts enabled cycles since the last clear and flags
// the TIMEOUT-th one, so the arbiter can abandon a memory that never answers.
module mem_arb_timer #(
    parameter int unsigned TIMEOUT = mem_arb_pkg::TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    import mem_arb_pkg::*;

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The count is the number of busy cycles already completed, so it reads
    // TIMEOUT-1 during the TIMEOUT-th busy cycle.
    assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory,
// with anti-starvation for fetch and a timeout for unresponsive accesses.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = mem_arb_pkg::STARVE_MAX_DEF,
    parameter int unsigned TIMEOUT    = mem_arb_pkg::TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        dm_stall_o,
    output logic        err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i
);
    import mem_arb_pkg::*;

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          if_ack_q, if_ack_d;
    logic          dm_ack_q, dm_ack_d;
    logic          err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;

    logic starve_at_max;
    logic busy;
    logic timer_expired;

    assign starve_at_max = (starve_q == SW'(STARVE_MAX));
    assign busy          = (state_q != ST_IDLE);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (!busy),
        .enable_i  (busy),
        .expired_o (timer_expired)
    );

    // Priority is chosen from the raw requests; a winner sitting in its own
    // ack cycle is not granted, and nobody else is either, which keeps
    // back-to-back data requests ahead of a fetch until the starve limit.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_ack_d   = 1'b0;
        dm_ack_d   = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req_i && (starve_at_max || !dm_req_i)) begin
                    if (!if_ack_q) begin
                        state_d  = ST_IF_BUSY;
                        addr_d   = if_addr_i;
                        we_d     = 1'b0;
                        starve_d = '0;
                    end
                end else if (dm_req_i) begin
                    if (!dm_ack_q) begin
                        state_d = ST_DM_BUSY;
                        addr_d  = dm_addr_i;
                        we_d    = dm_we_i;
                        wdata_d = dm_wdata_i;
                        if (if_req_i && !starve_at_max) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end

            ST_IF_BUSY: begin
                if (mem_ready_i) begin
                    state_d    = ST_IDLE;
                    if_ack_d   = 1'b1;
                    if_rdata_d = mem_rdata_i;
                end else if (timer_expired) begin
                    state_d  = ST_IDLE;
                    if_ack_d = 1'b1;
                    err_d    = 1'b1;
                end
            end

            ST_DM_BUSY: begin
                if (mem_ready_i) begin
                    state_d  = ST_IDLE;
                    dm_ack_d = 1'b1;
                    if (!we_q) begin
                        dm_rdata_d = mem_rdata_i;
                    end
                end else if (timer_expired) begin
                    state_d  = ST_IDLE;
                    dm_ack_d = 1'b1;
                    err_d    = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_ack_q   <= if_ack_d;
            dm_ack_q   <= dm_ack_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_en_o    = busy;
    assign mem_we_o    = (state_q == ST_DM_BUSY) && we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign if_ack_o   = if_ack_q;
    assign dm_ack_o   = dm_ack_q;
    assign err_o      = err_q;
    assign if_rdata_o = if_rdata_q;
    assign dm_rdata_o = dm_rdata_q;
    assign if_stall_o = if_req_i && !if_ack_q;
    assign dm_stall_o = dm_req_i && !dm_ack_q;

endmodule
